// File: rtl/dff_bank_write_arbiter.sv
// ============================================================================
// Module      : dff_bank_write_arbiter
// Description : Round-robin write arbiter and sole writer of a shared W-bit
//               q/qb register bank. Each write is a grant, commit and ack.
//               Optional macro DFF_ARB_LOCK_EN lets the owner keep the bank
//               for back-to-back writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dff_bank_write_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   wdata,
    input  logic [NREQ-1:0]     lock,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     ack,
    output logic [W-1:0]        q,
    output logic [W-1:0]        qb,
    output logic                busy
);

    localparam int IDX_W = $clog2(NREQ);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_last;
    logic [IDX_W-1:0]  w_last_nxt;
    logic [IDX_W-1:0]  r_win;
    logic [IDX_W-1:0]  w_win_nxt;
    logic [IDX_W-1:0]  w_pick;
    logic              w_found;
    int                w_idx;
    logic [NREQ-1:0]   w_gnt_nxt;
    logic [NREQ-1:0]   w_ack_nxt;
    logic [W-1:0]      w_q_nxt;
    logic [W-1:0]      w_qb_nxt;
    logic [W-1:0]      w_win_data;
    logic              w_hold;

    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        w_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = (int'(r_last) + k) % NREQ;
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(w_idx);
            end
        end
    end

    assign w_win_data = wdata[int'(r_win)*W +: W];

`ifdef DFF_ARB_LOCK_EN
    assign w_hold = lock[r_win] & req[r_win];
`else
    logic w_unused_lock;
    assign w_unused_lock = ^lock;
    assign w_hold        = 1'b0;
`endif

    assign busy = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_win_nxt   = r_win;
        w_gnt_nxt   = '0;
        w_ack_nxt   = '0;
        w_q_nxt     = q;
        w_qb_nxt    = qb;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_last_nxt  = w_pick;
                    w_win_nxt   = w_pick;
                    w_gnt_nxt   = onehot(w_pick);
                end
            end
            ST_GRANT: begin
                // Commit regardless of req: the grant already promised the write.
                w_q_nxt     = w_win_data;
                w_qb_nxt    = ~w_win_data;
                w_ack_nxt   = onehot(r_win);
                w_state_nxt = ST_ACK;
            end
            ST_ACK: begin
                if (w_hold) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = onehot(r_win);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_last  <= LAST_RST;
            r_win   <= '0;
            gnt     <= '0;
            ack     <= '0;
            q       <= '0;
            qb      <= '1;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_win   <= w_win_nxt;
            gnt     <= w_gnt_nxt;
            ack     <= w_ack_nxt;
            q       <= w_q_nxt;
            qb      <= w_qb_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dff_bank_write_arbiter.sv
// Bench for dff_bank_write_arbiter: timestamped transaction model feeds
// expected grants/acks into queues that a negedge monitor consumes.
`default_nettype none

module tb_dff_bank_write_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] wdata;
    logic [NREQ-1:0]   lock;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      q;
    logic [W-1:0]      qb;
    logic              busy;

    dff_bank_write_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .wdata (wdata),
        .lock  (lock),
        .gnt   (gnt),
        .ack   (ack),
        .q     (q),
        .qb    (qb),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         who;
        int         stamp;
        logic [7:0] d;
    } exp_t;

    exp_t gq[$];
    exp_t aq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state, expressed as edge timestamps.
    int         m_last = NREQ - 1;
    bit         m_free = 1'b1;
    int         m_who  = 0;
    bit         m_cpend = 1'b0;
    int         m_cedge = 0;
    bit         m_apend = 1'b0;
    int         m_aedge = 0;
    logic [7:0] m_q = 8'h00;

    always @(posedge clk) begin
        bit   was_free;
        exp_t e;
        cyc = cyc + 1;
        if (rst) begin
            gq.delete();
            aq.delete();
            m_q = 8'h00; m_last = NREQ - 1; m_free = 1'b1;
            m_cpend = 1'b0; m_apend = 1'b0;
        end else begin
            was_free = m_free;
            if (m_cpend && cyc == m_cedge) begin
                m_q = wdata[m_who*W +: W];
                e.who = m_who; e.stamp = cyc; e.d = m_q;
                aq.push_back(e);
                m_cpend = 1'b0; m_apend = 1'b1; m_aedge = cyc + 1;
            end else if (m_apend && cyc == m_aedge) begin
                m_apend = 1'b0;
`ifdef DFF_ARB_LOCK_EN
                if (lock[m_who] && req[m_who]) begin
                    e.who = m_who; e.stamp = cyc; e.d = 8'h00;
                    gq.push_back(e);
                    m_cpend = 1'b1; m_cedge = cyc + 1;
                end else begin
                    m_free = 1'b1;
                end
`else
                m_free = 1'b1;
`endif
            end
            if (was_free && req != '0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (req[(m_last + k) % NREQ]) begin
                        m_who = (m_last + k) % NREQ;
                        break;
                    end
                end
                m_last = m_who;
                e.who = m_who; e.stamp = cyc; e.d = 8'h00;
                gq.push_back(e);
                m_free = 1'b0; m_cpend = 1'b1; m_cedge = cyc + 1;
            end
        end
    end

    // Monitor: mid-cycle compare of every output against the model.
    always @(negedge clk) begin
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] ea;
        exp_t e;
        eg = '0;
        ea = '0;
        if (gq.size() > 0 && gq[0].stamp == cyc) begin
            e = gq.pop_front();
            eg[e.who] = 1'b1;
        end
        if (aq.size() > 0 && aq[0].stamp == cyc) begin
            e = aq.pop_front();
            ea[e.who] = 1'b1;
        end
        total++;
        if (gnt !== eg) begin
            bad++;
            $display("FAIL gnt cyc=%0d got=%b want=%b", cyc, gnt, eg);
        end
        total++;
        if (ack !== ea) begin
            bad++;
            $display("FAIL ack cyc=%0d got=%b want=%b", cyc, ack, ea);
        end
        total++;
        if (q !== m_q) begin
            bad++;
            $display("FAIL q cyc=%0d got=%h want=%h", cyc, q, m_q);
        end
        total++;
        if (qb !== ~m_q) begin
            bad++;
            $display("FAIL qb cyc=%0d got=%h want=%h", cyc, qb, ~m_q);
        end
        total++;
        if (busy !== !m_free) begin
            bad++;
            $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, !m_free);
        end
    end

    task automatic run_drop(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            req = req & ~ack;
        end
    endtask

    task automatic wait_gnt(input int idx);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            if (gnt[idx]) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL wait_gnt%0d got=timeout want=grant", idx);
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; lock = '0; wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single write from requester 2.
        wdata[2*W +: W] = 8'hA5;
        req = 4'b0100;
        run_drop(8);

        // Fairness with drop-on-ack, then with req held permanently.
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b1111;
        run_drop(16);
        req = 4'b1111;
        repeat (16) @(negedge clk);
        req = '0;
        repeat (4) @(negedge clk);

        // Requester 1 drops during GRANT; requester 3 arrives while busy.
        wdata[1*W +: W] = 8'h96;
        wdata[3*W +: W] = 8'hC3;
        req = 4'b0010;
        wait_gnt(1);
        req[1] = 1'b0;
        req[3] = 1'b1;
        run_drop(12);

        // Reset during GRANT aborts the write.
        wdata[0*W +: W] = 8'h3C;
        req = 4'b0001;
        wait_gnt(0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        repeat (4) @(negedge clk);

        // Lock on requester 0 with requester 1 also pending.
        wdata[0*W +: W] = 8'h5E;
        wdata[1*W +: W] = 8'h7F;
        lock = 4'b0001;
        req = 4'b0011;
        repeat (6) @(negedge clk);
        lock = '0;
        run_drop(10);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && ack[i]) begin
                    if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
                end else if (req[i] && $urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end else if (!req[i] && !gnt[i] && $urandom_range(0, 3) == 0) begin
                    wdata[i*W +: W] = W'($urandom);
                    req[i] = 1'b1;
                end
                if ($urandom_range(0, 7) == 0) lock[i] = ~lock[i];
            end
        end
        rst = 1'b0; req = '0; lock = '0;
        repeat (6) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
